// File: rtl/cga_slot_sequencer.sv
// CGA slot sequencer: free-running phase counter that splits each character period
// into 1, 2 or 4 fetch slots, issues per-slot VRAM strobes and arbitrates ISA access.
module cga_slot_sequencer #(
  parameter int PERIOD_LOG2 = 5,
  parameter int ISA_OP_LEN  = 3,
  parameter int PIPE_RESET  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             slot_mode,
  input  logic [PERIOD_LOG2-1:0] pipe_ofs,
  input  logic                   resync,
  input  logic                   isa_req,
  output logic [PERIOD_LOG2-1:0] clk_seq,
  output logic                   lclk,
  output logic                   hclk,
  output logic                   crtc_clk,
  output logic                   vram_read,
  output logic                   vram_read_a0,
  output logic                   vram_read_char,
  output logic                   vram_read_att,
  output logic                   charrom_read,
  output logic                   disp_pipeline,
  output logic                   isa_grant,
  output logic                   isa_busy
);

  localparam int BW = $clog2(ISA_OP_LEN + 1);

  logic [PERIOD_LOG2-1:0] seq;
  logic [PERIOD_LOG2-1:0] active_pipe;
  logic [PERIOD_LOG2-1:0] eff_seq;
  logic [PERIOD_LOG2-1:0] slot_mask;
  logic [PERIOD_LOG2-1:0] slot_ofs;
  logic [1:0]             active_mode;
  logic [1:0]             shift;
  logic [BW-1:0]          busy_cnt;
  logic                   grant_q;
  logic                   in_window;
  logic                   eligible;

  // Mode and pipeline offset are shadowed so a period is never split between settings.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seq         <= '0;
      active_mode <= 2'b00;
      active_pipe <= PERIOD_LOG2'(PIPE_RESET);
    end else begin
      seq <= resync ? '0 : seq + PERIOD_LOG2'(1);
      if (resync || (&seq)) begin
        active_mode <= slot_mode;
        active_pipe <= pipe_ofs;
      end
    end
  end

  always_comb begin
    shift = 2'd1;
    case (active_mode)
      2'b00:   shift = 2'd0;
      2'b10:   shift = 2'd2;
      default: shift = 2'd1;
    endcase
    slot_mask = {PERIOD_LOG2{1'b1}} >> shift;
  end

  assign eff_seq  = reset_n ? seq : '0;
  assign slot_ofs = eff_seq & slot_mask;

  // The whole operation must sit in offsets 5..L-2, so the grant decision is made at offset >= 4.
  assign in_window = (slot_ofs >= PERIOD_LOG2'(4)) &&
                     ((32'(slot_ofs) + 32'(ISA_OP_LEN) + 32'd1) <= 32'(slot_mask));

  // A new grant may coincide with the edge that ends the previous operation, giving back-to-back ops.
  assign eligible = isa_req && !resync && (busy_cnt <= BW'(1)) && in_window;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_cnt <= '0;
      grant_q  <= 1'b0;
    end else begin
      grant_q <= eligible;
      if (eligible) begin
        busy_cnt <= BW'(ISA_OP_LEN);
      end else if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - BW'(1);
      end
    end
  end

  assign clk_seq        = eff_seq;
  assign lclk           = (eff_seq == '0);
  assign hclk           = (eff_seq[PERIOD_LOG2-2:0] == '0);
  assign crtc_clk       = (slot_ofs == '0);
  assign vram_read      = (slot_ofs >= PERIOD_LOG2'(1)) && (slot_ofs <= PERIOD_LOG2'(3));
  assign vram_read_a0   = (slot_ofs == PERIOD_LOG2'(2));
  assign vram_read_char = (slot_ofs == PERIOD_LOG2'(2));
  assign vram_read_att  = (slot_ofs == PERIOD_LOG2'(3));
  assign charrom_read   = (slot_ofs == PERIOD_LOG2'(3));
  assign disp_pipeline  = reset_n && (slot_ofs == active_pipe) && (active_pipe <= slot_mask);
  assign isa_grant      = reset_n && grant_q;
  assign isa_busy       = reset_n && (busy_cnt != '0);

endmodule

// File: tb/tb_cga_slot_sequencer.sv
// Bench for cga_slot_sequencer: constant vector table, directed corner sequences and
// a long randomized run against a cycle-level behavioural model.
module tb_cga_slot_sequencer;

  localparam int PL  = 5;
  localparam int P   = 32;
  localparam int OPL = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    slot_mode;
  logic [PL-1:0] pipe_ofs;
  logic          resync;
  logic          isa_req;
  logic [PL-1:0] clk_seq;
  logic lclk, hclk, crtc_clk, vram_read, vram_read_a0, vram_read_char;
  logic vram_read_att, charrom_read, disp_pipeline, isa_grant, isa_busy;
  logic [8:0]    strobes;

  int checks = 0;
  int failures = 0;

  // Behavioural model state: busy_left counts remaining busy cycles including the current one.
  int m_seq, m_mode, m_pipe, m_busy;
  bit m_grant, m_rstn;

  cga_slot_sequencer #(.PERIOD_LOG2(PL), .ISA_OP_LEN(OPL), .PIPE_RESET(4)) dut (
    .clk(clk), .reset_n(reset_n), .slot_mode(slot_mode), .pipe_ofs(pipe_ofs),
    .resync(resync), .isa_req(isa_req), .clk_seq(clk_seq), .lclk(lclk), .hclk(hclk),
    .crtc_clk(crtc_clk), .vram_read(vram_read), .vram_read_a0(vram_read_a0),
    .vram_read_char(vram_read_char), .vram_read_att(vram_read_att),
    .charrom_read(charrom_read), .disp_pipeline(disp_pipeline),
    .isa_grant(isa_grant), .isa_busy(isa_busy)
  );

  always #5 clk = ~clk;

  assign strobes = {lclk, hclk, crtc_clk, vram_read, vram_read_a0, vram_read_char,
                    vram_read_att, charrom_read, disp_pipeline};

  function automatic int slotLen(int mode);
    if (mode == 0) return P;
    if (mode == 2) return P / 4;
    return P / 2;
  endfunction

  function automatic logic [15:0] modelOut();
    int es, len, o;
    logic [15:0] r;
    es  = m_rstn ? m_seq : 0;
    len = slotLen(m_mode);
    o   = es % len;
    r[15:11] = 5'(es);
    r[10] = (es == 0);
    r[9]  = ((es % (P / 2)) == 0);
    r[8]  = (o == 0);
    r[7]  = (o >= 1) && (o <= 3);
    r[6]  = (o == 2);
    r[5]  = (o == 2);
    r[4]  = (o == 3);
    r[3]  = (o == 3);
    r[2]  = m_rstn && (o == m_pipe);
    r[1]  = m_rstn && m_grant;
    r[0]  = m_rstn && (m_busy > 0);
    return r;
  endfunction

  function automatic void modelStep(bit rn, int mode, int pipe, bit rs, bit req);
    int len, o;
    bit elig;
    if (!rn) begin
      m_seq = 0; m_mode = 0; m_pipe = 4; m_busy = 0; m_grant = 1'b0;
    end else begin
      len  = slotLen(m_mode);
      o    = m_seq % len;
      elig = req && !rs && (m_busy <= 1) && (o + 1 >= 5) && (o + OPL <= len - 2);
      if (m_seq == P - 1 || rs) begin
        m_mode = mode;
        m_pipe = pipe;
      end
      m_seq = rs ? 0 : (m_seq + 1) % P;
      if (elig) begin
        m_grant = 1'b1;
        m_busy  = OPL;
      end else begin
        m_grant = 1'b0;
        if (m_busy > 0) m_busy--;
      end
    end
    m_rstn = rn;
  endfunction

  task automatic checkOutput(string name);
    logic [15:0] act, exp;
    act = {clk_seq, strobes, isa_grant, isa_busy};
    exp = modelOut();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s seq=%0d got=%h expected=%h", name, m_seq, act, exp);
    end
  endtask

  task automatic checkValue(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Starts and ends at a falling edge: drive, clock once, advance the model, compare.
  task automatic applyStimulus(bit rn, int mode, int pipe, bit rs, bit req);
    reset_n   = rn;
    slot_mode = 2'(mode);
    pipe_ofs  = 5'(pipe);
    resync    = rs;
    isa_req   = req;
    @(posedge clk);
    modelStep(rn, mode, pipe, rs, req);
    @(negedge clk);
    checkOutput("model");
  endtask

  typedef struct {
    string      name;
    int         mode;
    int         pipe;
    int         steps;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] gmask, bmask, mask;
    int overlap, gcount, bcount;

    vecs[0]  = '{"m00_seq0",        0,  4,  0, 9'b111000000};
    vecs[1]  = '{"m00_seq2_char",   0,  4,  2, 9'b000111000};
    vecs[2]  = '{"m00_seq3_att",    0,  4,  3, 9'b000100110};
    vecs[3]  = '{"m00_seq4_pipe",   0,  4,  4, 9'b000000001};
    vecs[4]  = '{"m00_seq16_hclk",  0,  4, 16, 9'b010000000};
    vecs[5]  = '{"m01_seq16_crtc",  1,  4, 16, 9'b011000000};
    vecs[6]  = '{"m01_pipe9_seq25", 1,  9, 25, 9'b000000001};
    vecs[7]  = '{"m01_pipe20_off",  1, 20, 20, 9'b000000000};
    vecs[8]  = '{"m10_seq25_vram",  2,  4, 25, 9'b000100000};
    vecs[9]  = '{"m11_seq19_att",   3,  4, 19, 9'b000100110};
    vecs[10] = '{"m10_pipe7_seq31", 2,  7, 31, 9'b000000001};
    vecs[11] = '{"m10_pipe8_none",  2,  8,  8, 9'b001000000};
    vecs[12] = '{"m00_pipe31",      0, 31, 31, 9'b000000001};

    reset_n = 1'b0; slot_mode = 2'b00; pipe_ofs = 5'd0; resync = 1'b0; isa_req = 1'b0;
    m_seq = 0; m_mode = 0; m_pipe = 4; m_busy = 0; m_grant = 1'b0; m_rstn = 1'b0;
    @(negedge clk);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    checkValue("reset_strobes", 32'(strobes), 32'h1C0);
    checkValue("reset_isa", {30'd0, isa_grant, isa_busy}, 32'd0);

    $display("[TB] vector table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1, vecs[i].mode, vecs[i].pipe, 1, 0);
      repeat (vecs[i].steps) applyStimulus(1, vecs[i].mode, vecs[i].pipe, 0, 0);
      checkValue(vecs[i].name, 32'(strobes), 32'(vecs[i].exp));
    end

    $display("[TB] mode change shadowed until wrap");
    applyStimulus(1, 0, 4, 1, 0);
    repeat (10) applyStimulus(1, 0, 4, 0, 0);
    repeat (6) applyStimulus(1, 1, 4, 0, 0);
    checkValue("mode_hold_crtc16", 32'(crtc_clk), 32'd0);
    repeat (32) applyStimulus(1, 1, 4, 0, 0);
    checkValue("mode_new_crtc16", 32'(crtc_clk), 32'd1);
    repeat (2) applyStimulus(1, 1, 4, 0, 0);
    checkValue("mode_new_char18", {clk_seq, vram_read_char}, {5'd18, 1'b1});

    $display("[TB] back-to-back ISA grants in mode 01");
    applyStimulus(1, 1, 4, 1, 0);
    gmask = '0; bmask = '0; overlap = 0;
    for (int i = 0; i < 32; i++) begin
      if (isa_grant) gmask[clk_seq] = 1'b1;
      if (isa_busy) bmask[clk_seq] = 1'b1;
      if (isa_busy && vram_read) overlap++;
      applyStimulus(1, 1, 4, 0, 1);
    end
    checkValue("isa_grant_seqs", gmask, 32'h0920_0920);
    checkValue("isa_busy_seqs", bmask, 32'h3FE0_3FE0);
    checkValue("isa_vram_overlap", 32'(overlap), 32'd0);

    $display("[TB] resync during an operation");
    applyStimulus(1, 1, 4, 1, 0);
    repeat (5) applyStimulus(1, 1, 4, 0, 1);
    checkValue("rs_grant_seq5", {clk_seq, isa_grant}, {5'd5, 1'b1});
    bcount = int'(isa_busy);
    applyStimulus(1, 1, 4, 0, 1);
    bcount += int'(isa_busy);
    applyStimulus(1, 1, 4, 1, 1);
    bcount += int'(isa_busy);
    checkValue("rs_seq0_busy", {clk_seq, isa_grant, isa_busy}, {5'd0, 1'b0, 1'b1});
    applyStimulus(1, 1, 4, 0, 1);
    bcount += int'(isa_busy);
    checkValue("rs_busy_total", 32'(bcount), 32'd3);
    repeat (3) applyStimulus(1, 1, 4, 0, 1);
    applyStimulus(1, 1, 4, 1, 1);
    checkValue("rs_blocks_grant", 32'(isa_grant), 32'd0);

    $display("[TB] pipeline offset shadowing");
    applyStimulus(1, 1, 9, 1, 0);
    mask = '0;
    for (int i = 0; i < 32; i++) begin
      if (disp_pipeline) mask[clk_seq] = 1'b1;
      applyStimulus(1, 1, (i < 10) ? 9 : 20, 0, 0);
    end
    checkValue("pipe9_seqs", mask, 32'h0200_0200);
    mask = '0;
    for (int i = 0; i < 32; i++) begin
      if (disp_pipeline) mask[clk_seq] = 1'b1;
      applyStimulus(1, 1, 20, 0, 0);
    end
    checkValue("pipe20_none", mask, 32'd0);

    $display("[TB] mode 10 never grants");
    applyStimulus(1, 2, 4, 1, 0);
    mask = '0; gcount = 0;
    for (int i = 0; i < 64; i++) begin
      if (vram_read && i < 32) mask[clk_seq] = 1'b1;
      if (isa_grant) gcount++;
      applyStimulus(1, 2, 4, 0, 1);
    end
    checkValue("m10_vram_seqs", mask, 32'h0E0E_0E0E);
    checkValue("m10_no_grant", 32'(gcount), 32'd0);

    $display("[TB] reset during an operation");
    applyStimulus(1, 1, 4, 1, 0);
    repeat (5) applyStimulus(1, 1, 4, 0, 1);
    checkValue("rst_pre_busy", 32'(isa_busy), 32'd1);
    applyStimulus(0, 1, 4, 0, 1);
    checkValue("rst_clears_isa", {clk_seq, isa_grant, isa_busy}, {5'd0, 1'b0, 1'b0});
    checkValue("rst_strobes", 32'(strobes), 32'h1C0);

    $display("[TB] randomized run");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 49) != 0, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 31)), $urandom_range(0, 29) == 0,
                    1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
